// File: rtl/zone_bl_tx.sv
// zone_bl_tx: ping-pong buffer for per-zone backlight values plus a serial
// clock/data/latch transmitter. Each accepted frame sync shifts the
// completed frame to the MiniLED driver chain, MSB of zone 0 first.
module zone_bl_tx #(
    parameter int ZONES   = 360,
    parameter int DW      = 8,
    parameter int CLK_DIV = 4
) (
    input  logic          i_pix_clk,
    input  logic          rst,
    input  logic          flag_done,
    input  logic [8:0]    cnt_360,
    input  logic [DW-1:0] buf_360_flatted,
    input  logic          r_Vsync_0,
    input  logic          bl_en,
    output logic          led_sclk,
    output logic          led_sdo,
    output logic          led_lat,
    output logic          tx_busy,
    output logic          frame_drop,
    output logic          addr_err
);

    localparam int ZW = (ZONES > 1) ? $clog2(ZONES) : 1;
    localparam int BW = (DW > 1) ? $clog2(DW) : 1;
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [9:0]    ZLIM      = 10'(ZONES);
    localparam logic [ZW-1:0] ZONE_LAST = ZW'(ZONES - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DW - 1);
    localparam logic [CW-1:0] DIV_LAST  = CW'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        LATCH
    } state_t;

    state_t state;

    logic [DW-1:0] bank0 [ZONES];
    logic [DW-1:0] bank1 [ZONES];

    logic          wsel;
    logic          armed;
    logic          vs_d;
    logic          phase;
    logic [ZW-1:0] zone;
    logic [ZW-1:0] raddr;
    logic [ZW-1:0] waddr;
    logic [BW-1:0] bitc;
    logic [CW-1:0] divc;
    logic [DW-1:0] shreg;
    logic [DW-1:0] shnext;
    logic [DW-1:0] rdata;
    logic [DW-1:0] ldata;
    logic          sync_edge;
    logic          wr_ok;

    assign sync_edge = r_Vsync_0 && !vs_d;
    assign wr_ok     = flag_done && ({1'b0, cnt_360} < ZLIM);
    assign waddr     = ZW'(cnt_360);
    assign shnext    = shreg << 1;
    assign ldata     = bl_en ? rdata : '0;

    // Read address: zone 0 while loading, otherwise prefetch the next zone
    // so its data is ready at the zone boundary without a gap.
    always_comb begin
        raddr = '0;
        if (state == SHIFT && zone != ZONE_LAST) begin
            raddr = zone + 1'b1;
        end
    end

    // Zone storage: write into the write bank, synchronous read of the other bank.
    always_ff @(posedge i_pix_clk) begin
        if (wr_ok && !wsel) begin
            bank0[waddr] <= buf_360_flatted;
        end
        if (wr_ok && wsel) begin
            bank1[waddr] <= buf_360_flatted;
        end
        rdata <= wsel ? bank0[raddr] : bank1[raddr];
    end

    // Sync detection, arming, bank swap and the serial transmit FSM.
    always_ff @(posedge i_pix_clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            vs_d       <= 1'b0;
            armed      <= 1'b0;
            wsel       <= 1'b0;
            phase      <= 1'b0;
            zone       <= '0;
            bitc       <= '0;
            divc       <= '0;
            shreg      <= '0;
            led_sclk   <= 1'b0;
            led_sdo    <= 1'b0;
            led_lat    <= 1'b0;
            tx_busy    <= 1'b0;
            frame_drop <= 1'b0;
            addr_err   <= 1'b0;
        end else begin
            vs_d       <= r_Vsync_0;
            frame_drop <= 1'b0;

            if (flag_done && !wr_ok) begin
                addr_err <= 1'b1;
            end

            if (sync_edge) begin
                if (!armed) begin
                    armed <= 1'b1;
                end else if (state != IDLE) begin
                    frame_drop <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (sync_edge && armed) begin
                        wsel    <= !wsel;
                        tx_busy <= 1'b1;
                        phase   <= 1'b0;
                        state   <= LOAD;
                    end
                end

                LOAD: begin
                    if (!phase) begin
                        phase <= 1'b1;
                    end else begin
                        phase    <= 1'b0;
                        shreg    <= ldata;
                        led_sdo  <= ldata[DW-1];
                        led_sclk <= 1'b0;
                        zone     <= '0;
                        bitc     <= '0;
                        divc     <= '0;
                        state    <= SHIFT;
                    end
                end

                SHIFT: begin
                    if (divc != DIV_LAST) begin
                        divc <= divc + 1'b1;
                    end else begin
                        divc <= '0;
                        if (!led_sclk) begin
                            led_sclk <= 1'b1;
                        end else begin
                            led_sclk <= 1'b0;
                            if (bitc != BIT_LAST) begin
                                bitc    <= bitc + 1'b1;
                                shreg   <= shnext;
                                led_sdo <= shnext[DW-1];
                            end else begin
                                bitc <= '0;
                                if (zone == ZONE_LAST) begin
                                    zone    <= '0;
                                    led_sdo <= 1'b0;
                                    led_lat <= 1'b1;
                                    phase   <= 1'b0;
                                    state   <= LATCH;
                                end else begin
                                    zone    <= zone + 1'b1;
                                    shreg   <= ldata;
                                    led_sdo <= ldata[DW-1];
                                end
                            end
                        end
                    end
                end

                LATCH: begin
                    // Two divider periods, tracked by the phase bit.
                    if (divc != DIV_LAST) begin
                        divc <= divc + 1'b1;
                    end else begin
                        divc <= '0;
                        if (!phase) begin
                            phase <= 1'b1;
                        end else begin
                            phase   <= 1'b0;
                            led_lat <= 1'b0;
                            tx_busy <= 1'b0;
                            state   <= IDLE;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_zone_bl_tx.sv
// tb_zone_bl_tx: randomized frames checked against a frame-level model of
// the ping-pong buffer and the serial link timing.
module tb_zone_bl_tx;

    localparam int ZONES     = 360;
    localparam int DW        = 8;
    localparam int CLK_DIV   = 4;
    localparam int SHIFT_CYC = ZONES * DW * 2 * CLK_DIV;
    localparam int LAT_CYC   = 2 * CLK_DIV;

    logic          clk = 1'b0;
    logic          rst;
    logic          flag_done;
    logic [8:0]    cnt;
    logic [DW-1:0] din;
    logic          r_vsync;
    logic          bl_en;
    logic          led_sclk;
    logic          led_sdo;
    logic          led_lat;
    logic          tx_busy;
    logic          frame_drop;
    logic          addr_err;

    zone_bl_tx #(
        .ZONES  (ZONES),
        .DW     (DW),
        .CLK_DIV(CLK_DIV)
    ) dut (
        .i_pix_clk      (clk),
        .rst            (rst),
        .flag_done      (flag_done),
        .cnt_360        (cnt),
        .buf_360_flatted(din),
        .r_Vsync_0      (r_vsync),
        .bl_en          (bl_en),
        .led_sclk       (led_sclk),
        .led_sdo        (led_sdo),
        .led_lat        (led_lat),
        .tx_busy        (tx_busy),
        .frame_drop     (frame_drop),
        .addr_err       (addr_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Link monitor, sampled on the falling clock edge.
    logic prev_sclk = 1'b0;
    logic prev_lat  = 1'b0;
    logic prev_busy = 1'b0;
    int   lat_t0    = 0;
    bit   bits[$];
    int   bit_cyc[$];
    int   lat_start[$];
    int   lat_len[$];
    int   busy_rise[$];
    int   busy_fall[$];
    int   drop_cyc[$];

    always @(negedge clk) begin
        if (led_sclk && !prev_sclk) begin
            bits.push_back(led_sdo);
            bit_cyc.push_back(cyc);
        end
        if (led_lat && !prev_lat) lat_t0 = cyc;
        if (!led_lat && prev_lat) begin
            lat_start.push_back(lat_t0);
            lat_len.push_back(cyc - lat_t0);
        end
        if (tx_busy && !prev_busy) busy_rise.push_back(cyc);
        if (!tx_busy && prev_busy) busy_fall.push_back(cyc);
        if (frame_drop) drop_cyc.push_back(cyc);
        prev_sclk = led_sclk;
        prev_lat  = led_lat;
        prev_busy = tx_busy;
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Frame-level model: buffer being filled, buffer on display, link timing.
    logic [DW-1:0] m_wbuf    [ZONES];
    logic [DW-1:0] m_dbuf    [ZONES];
    logic [DW-1:0] exp_frame [ZONES];
    logic [DW-1:0] exp_hold  [ZONES];
    bit            m_armed      = 1'b0;
    int            m_busy_until = -1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int z, input logic [DW-1:0] d);
        flag_done = 1'b1;
        cnt       = 9'(z);
        din       = d;
        tick();
        flag_done = 1'b0;
        if (z < ZONES) m_wbuf[z] = d;
    endtask

    // res: 0 = arms only, 1 = accepted (swap + transmit), 2 = dropped
    task automatic sync_edge(input bit w, input int z, input logic [DW-1:0] d,
                             output int e, output int res);
        logic [DW-1:0] tmp;
        e       = cyc;
        r_vsync = 1'b1;
        if (w) begin
            flag_done = 1'b1;
            cnt       = 9'(z);
            din       = d;
            if (z < ZONES) m_wbuf[z] = d;
        end
        if (!m_armed) begin
            m_armed = 1'b1;
            res     = 0;
        end else if (e <= m_busy_until) begin
            res = 2;
        end else begin
            res = 1;
            for (int i = 0; i < ZONES; i++) begin
                tmp          = m_dbuf[i];
                m_dbuf[i]    = m_wbuf[i];
                m_wbuf[i]    = tmp;
                exp_frame[i] = bl_en ? m_dbuf[i] : '0;
            end
            m_busy_until = e + 3 + SHIFT_CYC + LAT_CYC - 1;
        end
        tick();
        flag_done = 1'b0;
        tick();
        r_vsync = 1'b0;
    endtask

    task automatic hold_expected();
        for (int i = 0; i < ZONES; i++) exp_hold[i] = exp_frame[i];
    endtask

    // Checks one complete frame against exp_hold; indices locate the
    // monitor records that belong to this frame.
    task automatic check_frame(input string nm, input int e, input int b0,
                               input int nl0, input int nr0, input int nf0);
        int            waited = 0;
        logic [DW-1:0] v;
        while (lat_start.size() <= nl0 && waited < SHIFT_CYC + 200) begin
            tick();
            waited++;
        end
        check({nm, "_latch_seen"}, lat_start.size() > nl0, 1);
        if (lat_start.size() <= nl0) return;
        check({nm, "_busy_rise"}, (busy_rise.size() > nr0) ? busy_rise[nr0] : -1, e + 1);
        check({nm, "_nbits"}, bits.size() - b0, ZONES * DW);
        check({nm, "_lat_start"}, lat_start[nl0], e + 3 + SHIFT_CYC);
        check({nm, "_lat_len"}, lat_len[nl0], LAT_CYC);
        check({nm, "_busy_fall"}, (busy_fall.size() > nf0) ? busy_fall[nf0] : -1,
              e + 3 + SHIFT_CYC + LAT_CYC);
        if (bits.size() - b0 < ZONES * DW) return;
        check({nm, "_first_sclk"}, bit_cyc[b0], e + 3 + CLK_DIV);
        for (int z = 0; z < ZONES; z++) begin
            v = '0;
            for (int k = 0; k < DW; k++) v = {v[DW-2:0], bits[b0 + z * DW + k]};
            check($sformatf("%s_zone%0d", nm, z), v, exp_hold[z]);
        end
    endtask

    initial begin
        int            e;
        int            e2;
        int            res;
        int            b0;
        int            nl0;
        int            nr0;
        int            nf0;
        int            nd0;
        int            waited;
        logic [DW-1:0] d;
        logic [DW-1:0] v;

        rst       = 1'b0;
        flag_done = 1'b0;
        cnt       = '0;
        din       = '0;
        r_vsync   = 1'b0;
        bl_en     = 1'b1;
        #2 rst = 1'b1;
        #1;
        check("rst_sclk", led_sclk, 0);
        check("rst_sdo", led_sdo, 0);
        check("rst_lat", led_lat, 0);
        check("rst_busy", tx_busy, 0);
        check("rst_drop", frame_drop, 0);
        check("rst_addr_err", addr_err, 0);
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Frame A data: zone i = i[7:0]
        for (int i = 0; i < ZONES; i++) wr(i, 8'(i));

        // First edge after reset only arms
        nd0 = drop_cyc.size();
        nr0 = busy_rise.size();
        sync_edge(1'b0, 0, '0, e, res);
        repeat (10) tick();
        check("arm_no_busy", busy_rise.size(), nr0);
        check("arm_no_drop", drop_cyc.size(), nd0);
        check("arm_busy_lvl", tx_busy, 0);

        // Frame A
        b0  = bits.size();
        nl0 = lat_start.size();
        nr0 = busy_rise.size();
        nf0 = busy_fall.size();
        sync_edge(1'b0, 0, '0, e, res);
        hold_expected();

        // Frame B data written while A is on the link, plus a bad index
        for (int z = 0; z < ZONES; z++) begin
            d = 8'($urandom);
            while (d == 8'hAA) d = 8'($urandom);
            wr(z, d);
        end
        check("addr_err_pre", addr_err, 0);
        wr(ZONES, 8'hAA);
        check("addr_err_set", addr_err, 1);

        // Sync edge while busy
        while (cyc < e + 1000) tick();
        nd0 = drop_cyc.size();
        sync_edge(1'b0, 0, '0, e2, res);
        check("drop_count", drop_cyc.size(), nd0 + 1);
        check("drop_cycle", (drop_cyc.size() > nd0) ? drop_cyc[drop_cyc.size() - 1] : -1, e2 + 1);
        check_frame("A", e, b0, nl0, nr0, nf0);
        check("A_no_extra_busy", busy_rise.size(), nr0 + 1);

        // Frame B: zone 5 written in the swap cycle itself
        while (cyc <= m_busy_until + 5) tick();
        b0  = bits.size();
        nl0 = lat_start.size();
        nr0 = busy_rise.size();
        nf0 = busy_fall.size();
        sync_edge(1'b1, 5, 8'h3C, e, res);
        hold_expected();
        check("addr_err_sticky", addr_err, 1);
        for (int z = 0; z < ZONES; z++) wr(z, 8'($urandom));

        // Blank frame, edge one cycle after tx_busy fell
        while (cyc < m_busy_until + 1) tick();
        bl_en = 1'b0;
        sync_edge(1'b0, 0, '0, e2, res);
        check_frame("B", e, b0, nl0, nr0, nf0);
        b0  = bits.size() - bit_cyc.size() + bit_cyc.size();
        for (int i = 0; i < bit_cyc.size(); i++) begin
            if (bit_cyc[i] < e2) b0 = i + 1;
        end
        nl0 = lat_start.size();
        nr0 = nr0 + 1;
        nf0 = nf0 + 1;
        hold_expected();
        check_frame("BLANK", e2, b0, nl0, nr0, nf0);
        bl_en = 1'b1;

        // Reset in the middle of a transmission
        while (cyc <= m_busy_until + 5) tick();
        sync_edge(1'b0, 0, '0, e, res);
        repeat (500) tick();
        check("mid_busy", tx_busy, 1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_sclk", led_sclk, 0);
        check("mid_rst_sdo", led_sdo, 0);
        check("mid_rst_lat", led_lat, 0);
        check("mid_rst_busy", tx_busy, 0);
        check("mid_rst_drop", frame_drop, 0);
        check("mid_rst_addr_err", addr_err, 0);
        tick();
        rst          = 1'b0;
        m_armed      = 1'b0;
        m_busy_until = -1;
        tick();

        nr0 = busy_rise.size();
        sync_edge(1'b0, 0, '0, e, res);
        repeat (10) tick();
        check("rearm_no_busy", busy_rise.size(), nr0);
        for (int z = 0; z < ZONES; z++) wr(z, 8'($urandom));

        b0 = bits.size();
        sync_edge(1'b0, 0, '0, e, res);
        check("post_busy_rise", (busy_rise.size() > nr0) ? busy_rise[nr0] : -1, e + 1);
        waited = 0;
        while (bits.size() < b0 + 16 * DW && waited < 20 * DW * 2 * CLK_DIV) begin
            tick();
            waited++;
        end
        check("post_bits_seen", bits.size() >= b0 + 16 * DW, 1);
        if (bits.size() >= b0 + 16 * DW) begin
            check("post_first_sclk", bit_cyc[b0], e + 3 + CLK_DIV);
            for (int z = 0; z < 16; z++) begin
                v = '0;
                for (int k = 0; k < DW; k++) v = {v[DW-2:0], bits[b0 + z * DW + k]};
                check($sformatf("post_zone%0d", z), v, exp_frame[z]);
            end
        end
        check("drop_total", drop_cyc.size(), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/zone_bl_tx.md
# zone_bl_tx

Backlight-zone transmitter at the output of the 360-zone statistics block. Captures the per-zone 8-bit backlight values strobed in with `flag_done`/`cnt_360` into a ping-pong zone buffer. On each frame boundary (`r_Vsync_0` rising edge) it swaps banks and shifts the completed frame, MSB first, to the MiniLED driver chain over a clock/data/latch serial link.

## Interface
- `ZONES`, 360, zones per frame (buffer depth)
- `DW`, 8, bits per zone value
- `CLK_DIV`, 4, `i_pix_clk` cycles per `led_sclk` half-period (≥1)
- `i_pix_clk`  in  1  pixel clock; single clock domain
- `rst`  in  1  asynchronous, active-high reset
- `flag_done`  in  1  one-cycle strobe: `buf_360_flatted` is valid for zone `cnt_360`
- `cnt_360`  in  9  zone index of the current strobe
- `buf_360_flatted`  in  DW  zone backlight value
- `r_Vsync_0`  in  1  frame sync; rising edge marks frame end
- `bl_en`  in  1  1 = transmit buffer data, 0 = transmit all-zero (blank) data
- `led_sclk`  out  1  serial clock to driver chain; data sampled on rising edge
- `led_sdo`  out  1  serial data, MSB of zone 0 first
- `led_lat`  out  1  latch pulse after the last bit
- `tx_busy`  out  1  high from bank swap until the latch pulse ends
- `frame_drop`  out  1  one-cycle pulse: sync edge ignored because the transmitter was busy
- `addr_err`  out  1  sticky: strobe seen with `cnt_360 >= ZONES`; cleared only by `rst`

## Operation
- Storage: two banks of ZONES×DW. `wsel` selects the write bank; the read bank is `!wsel`. Memories are not reset.
- Write: on `flag_done` with `cnt_360 < ZONES`, write `buf_360_flatted` to `wbank[cnt_360]`. Later writes to the same index overwrite earlier ones.
  - If `cnt_360 >= ZONES`: no write; set `addr_err`.
- Sync detect: register `r_Vsync_0` into `vs_d`. Edge E is the cycle where `r_Vsync_0 = 1` and `vs_d = 0`.
- Arming: the first edge after reset only sets `armed`. It causes no swap, no transmission and no `frame_drop`.
- Edge with `armed` and state IDLE: toggle `wsel` and enter LOAD.
  - A `flag_done` in cycle E writes the pre-swap bank, so that value is transmitted.
- Edge with state ≠ IDLE: pulse `frame_drop`; no swap. The write bank keeps accepting data.
- FSM states:
  - IDLE: wait for a sync edge as above.
  - LOAD (2 cycles): address zone 0, then capture the read data into the shift register. If `bl_en = 0`, load 0 instead.
  - SHIFT: DW bits per zone, MSB first. Each bit is CLK_DIV cycles with `led_sclk` low, then CLK_DIV cycles with `led_sclk` high.
    - `led_sdo` changes only at the start of the low phase.
    - The next zone is prefetched during the current zone, so there is no gap between zones.
    - `bl_en` is sampled at each zone load.
    - After the last bit of zone ZONES-1, go to LATCH.
  - LATCH: `led_sclk = 0`, `led_sdo = 0`, `led_lat = 1` for 2×CLK_DIV cycles, then IDLE.
- Counters: bit counter 0..DW-1; zone counter 0..ZONES-1, wrapping to 0 on LATCH entry; divider counter 0..CLK_DIV-1.

## Timing
- Reset values (asynchronous): `led_sclk`, `led_sdo`, `led_lat`, `tx_busy`, `frame_drop`, `addr_err` = 0; `wsel` = 0; `armed` = 0; `vs_d` = 0; FSM in IDLE; all counters 0.
- Reset asserted mid-operation forces all outputs to 0 immediately. Transmission resumes only after re-arming plus a further sync edge.
- Cycle E+1: `tx_busy = 1`, state LOAD, `wsel` toggled.
- Cycle E+3: first bit on `led_sdo`, `led_sclk` low. First `led_sclk` rising edge at E+3+CLK_DIV.
- Shift duration: ZONES×DW×2×CLK_DIV cycles (defaults: 23040).
- `led_lat` high from E+3+23040 for 8 cycles. `tx_busy` falls together with `led_lat`.
- A sync edge in the cycle `tx_busy` falls is still dropped. An edge one cycle later is accepted.
- `frame_drop` is asserted in cycle E+1 (registered).
- `addr_err` is set in the cycle after the offending strobe.
- Write path has no back-pressure; a strobe is accepted every cycle.

## Test plan
- Full frame: arm, write zone i = i[7:0] for i = 0..359, sync edge → zone 0 byte `0x00`, zone 255 `0xFF`, zone 359 `0x67` decoded at `led_sclk` rising edges; 2880 bits total; `led_lat` high for 8 cycles at E+23043.
- Blanking: same frame with `bl_en = 0` → all 2880 bits are 0; `led_lat` still pulses; `tx_busy` timing unchanged.
- Busy sync: second sync edge 1000 cycles after the first → `frame_drop` = 1 for one cycle, transmission continues unchanged, `wsel` not toggled. The next frame transmits data written since the first swap.
- Bad index: `flag_done` with `cnt_360 = 360`, data `0xAA` → `addr_err` = 1 and stays 1. Next frame is unaffected; no zone reads `0xAA`.
- Arming/reset: first sync edge after reset → no `tx_busy`, no `frame_drop`. Assert `rst` mid-SHIFT → all outputs 0 immediately. After release, one edge arms only, and the following edge transmits.
- Swap-cycle write: `flag_done` for zone 5 with `0x3C` in cycle E → transmitted zone 5 = `0x3C`.
